// File: rtl/poly_pkg.sv
// Shared encodings for the poly datapath: operand-A/B selects, ALU ops, default width.
package poly_pkg;

   localparam int unsigned DEF_WIDTH = 16;

   localparam logic [1:0] SELA_ZERO = 2'b00;
   localparam logic [1:0] SELA_X    = 2'b01;
   localparam logic [1:0] SELA_H    = 2'b10;
   localparam logic [1:0] SELA_S    = 2'b11;

   localparam logic [1:0] SELB_X    = 2'b00;
   localparam logic [1:0] SELB_K0   = 2'b01;
   localparam logic [1:0] SELB_H    = 2'b10;
   localparam logic [1:0] SELB_K1   = 2'b11;

   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_SUB    = 2'b01;
   localparam logic [1:0] OP_MUL    = 2'b10;
   localparam logic [1:0] OP_PASS   = 2'b11;

endpackage

// File: rtl/poly_alu.sv
// Combinational ALU: add/sub/mul/pass with an overflow indication for the current op.
module poly_alu
   import poly_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] y,
   output logic             ovf_now
);

   localparam int unsigned PW = 2 * WIDTH;

   logic [WIDTH:0]  w_sum;
   logic [PW-1:0]   w_prod;

   assign w_sum  = {1'b0, a} + {1'b0, b};
   assign w_prod = PW'(a) * PW'(b);

   always_comb begin
      y       = a;
      ovf_now = 1'b0;
      unique case (op)
         OP_ADD: begin
            y       = w_sum[WIDTH-1:0];
            ovf_now = w_sum[WIDTH];
         end
         OP_SUB: begin
            y       = a - b;
            ovf_now = (a < b);
         end
         OP_MUL: begin
            y       = w_prod[WIDTH-1:0];
            ovf_now = |w_prod[PW-1:WIDTH];
         end
         OP_PASS: begin
            y       = a;
            ovf_now = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/poly_datapath.sv
// Datapath under the sequencing controller: X/H/S working registers around one shared ALU,
// result capture on the rising edge of finished and a valid/ready hand-off downstream.
module poly_datapath
   import poly_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned K0    = 3,
   parameter int unsigned K1    = 5
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             LX,
   input  logic             LH,
   input  logic             LS,
   input  logic             H,
   input  logic [1:0]       M0,
   input  logic [1:0]       M1,
   input  logic [1:0]       M2,
   input  logic             finished,
   input  logic [WIDTH-1:0] x_in,
   output logic [WIDTH-1:0] result,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             ovf,
   output logic             overrun
);

   localparam logic [WIDTH-1:0] K0_W = WIDTH'(K0);
   localparam logic [WIDTH-1:0] K1_W = WIDTH'(K1);

   logic [WIDTH-1:0] r_x, r_h, r_s, r_result;
   logic             r_res_valid, r_ovf, r_overrun, r_fin_d;
   logic [WIDTH-1:0] w_a, w_b, w_alu;
   logic             w_ovf_now, w_cap, w_xfer, w_alu_load;

   always_comb begin
      w_a = '0;
      unique case (M0)
         SELA_ZERO: w_a = '0;
         SELA_X:    w_a = r_x;
         SELA_H:    w_a = r_h;
         SELA_S:    w_a = r_s;
      endcase
   end

   always_comb begin
      w_b = r_x;
      unique case (M1)
         SELB_X:  w_b = r_x;
         SELB_K0: w_b = K0_W;
         SELB_H:  w_b = r_h;
         SELB_K1: w_b = K1_W;
      endcase
   end

   poly_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .a       (w_a),
      .b       (w_b),
      .op      (M2),
      .y       (w_alu),
      .ovf_now (w_ovf_now)
   );

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_x <= '0;
         r_h <= '0;
         r_s <= '0;
      end else begin
         if (LX) r_x <= H ? x_in : w_alu;
         if (LH) r_h <= w_alu;
         if (LS) r_s <= w_alu;
      end
   end

   // Only loads that actually take the ALU value can flag a lost bit.
   assign w_alu_load = LH | LS | (LX & ~H);

   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_ovf <= 1'b0;
      end else if (LX && H) begin
         r_ovf <= 1'b0;
      end else if (w_alu_load && w_ovf_now) begin
         r_ovf <= 1'b1;
      end
   end

   assign w_cap  = finished & ~r_fin_d;
   assign w_xfer = r_res_valid & res_ready;

   // Capture reads r_s before any same-cycle LS update, so the old S is taken.
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         r_fin_d     <= 1'b0;
         r_result    <= '0;
         r_res_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_fin_d <= finished;
         if (w_cap && (!r_res_valid || res_ready)) begin
            r_result    <= r_s;
            r_res_valid <= 1'b1;
         end else if (w_xfer) begin
            r_res_valid <= 1'b0;
         end
         if (w_cap && r_res_valid && !res_ready) r_overrun <= 1'b1;
      end
   end

   assign result    = r_result;
   assign res_valid = r_res_valid;
   assign ovf       = r_ovf;
   assign overrun   = r_overrun;

endmodule
